// File: rtl/usbdev_pkg.sv
// Shared USB device types.
// Line-state encoding used by the link and receive logic.
package usbdev_pkg;

  typedef enum logic [1:0] {
    LineSe0 = 2'd0,
    LineJ   = 2'd1,
    LineK   = 2'd2,
    LineSe1 = 2'd3
  } usb_line_state_e;

  function automatic usb_line_state_e decode_line(
    input logic dp,
    input logic dn
  );
    usb_line_state_e ls;
    ls = LineSe0;
    unique case (1'b1)
      (dp && !dn): ls = LineJ;
      (!dp && dn): ls = LineK;
      (dp && dn):  ls = LineSe1;
      default:     ls = LineSe0;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usbdev_line_monitor_if.sv
// Line-condition indications from the line monitor
// to the link-state tracker.
interface usbdev_line_monitor_if;

  logic       us_tick;
  logic [1:0] line_state;
  logic       rx_j_det;
  logic       rx_idle_det;
  logic       se1_err;

  modport master (
    output us_tick,
    output line_state,
    output rx_j_det,
    output rx_idle_det,
    output se1_err
  );

  modport slave (
    input us_tick,
    input line_state,
    input rx_j_det,
    input rx_idle_det,
    input se1_err
  );

endinterface

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer for asynchronous inputs.
// Reset value is applied to both stages.
module prim_flop_2sync #(
  parameter int unsigned      Width      = 2,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] s1_q;
  logic [Width-1:0] s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= ResetValue;
      s2_q <= ResetValue;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/usbdev_line_monitor.sv
// USB line-condition monitor: decodes D+/D-, times line-state runs
// and emits microsecond tick, J, idle and SE1 indications.
module usbdev_line_monitor
  import usbdev_pkg::*;
#(
  parameter int unsigned TickCycles = 48,
  parameter int unsigned BitCycles  = 4,
  parameter int unsigned IdleBits   = 7
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_ni,
  input  logic       usb_dp_i,
  input  logic       usb_dn_i,
  input  logic       cfg_pinflip_i,
  input  logic       usb_oe_i,
  output logic       us_tick_o,
  output logic [1:0] line_state_o,
  output logic       rx_j_det_o,
  output logic       rx_idle_det_o,
  output logic       se1_err_o
);

  localparam int unsigned RunMax = IdleBits * BitCycles;
  localparam int unsigned RunW   = $clog2(RunMax + 1);
  localparam int unsigned TickW  = $clog2(TickCycles);

  logic [1:0]      pins_sync;
  logic            dp_s;
  logic            dn_s;
  usb_line_state_e line_d;
  usb_line_state_e line_q;
  logic [RunW-1:0] run_q;
  logic            j_det_q;
  logic            idle_q;
  logic            se1_q;
  logic [TickW-1:0] tick_cnt_q;
  logic            tick_q;
  logic            run_bit;
  logic            run_full;

  prim_flop_2sync #(
    .Width      (2),
    .ResetValue (2'b00)
  ) u_sync (
    .clk_i  (clk_48mhz_i),
    .rst_ni (rst_ni),
    .d_i    ({usb_dp_i, usb_dn_i}),
    .q_o    (pins_sync)
  );

  assign dp_s   = cfg_pinflip_i ? pins_sync[0] : pins_sync[1];
  assign dn_s   = cfg_pinflip_i ? pins_sync[1] : pins_sync[0];
  assign line_d = decode_line(dp_s, dn_s);

  assign run_bit  = (run_q == RunW'(BitCycles));
  assign run_full = (run_q == RunW'(RunMax));

  // A driven bus holds the run at 0 so timing restarts on release.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= LineSe0;
      run_q  <= '0;
    end else begin
      line_q <= line_d;
      if (usb_oe_i) begin
        run_q <= '0;
      end else if (line_d != line_q) begin
        run_q <= RunW'(1);
      end else if (!run_full) begin
        run_q <= run_q + RunW'(1);
      end
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      j_det_q <= 1'b0;
      idle_q  <= 1'b0;
      se1_q   <= 1'b0;
    end else begin
      j_det_q <= !usb_oe_i && (line_q == LineJ) && run_bit;
      idle_q  <= !usb_oe_i && (line_q == LineJ) && run_full;
      se1_q   <= !usb_oe_i && (line_q == LineSe1) && run_bit;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= (tick_cnt_q == TickW'(TickCycles - 1));
      if (tick_cnt_q == TickW'(TickCycles - 1)) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + TickW'(1);
      end
    end
  end

  assign us_tick_o     = tick_q;
  assign line_state_o  = line_q;
  assign rx_j_det_o    = j_det_q;
  assign rx_idle_det_o = idle_q;
  assign se1_err_o     = se1_q;

endmodule

// File: tb/tb_usbdev_line_monitor.sv
// Randomized bench for usbdev_line_monitor against a
// history-based reference model of the line rules.
module tb_usbdev_line_monitor;

  localparam int TC   = 48;
  localparam int BC   = 4;
  localparam int IB   = 7;
  localparam int MAXR = IB * BC;
  localparam int NMAX = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic dp    = 1'b0;
  logic dn    = 1'b0;
  logic flip  = 1'b0;
  logic oe    = 1'b0;

  usbdev_line_monitor_if mon ();

  usbdev_line_monitor #(
    .TickCycles (TC),
    .BitCycles  (BC),
    .IdleBits   (IB)
  ) dut (
    .clk_48mhz_i   (clk),
    .rst_ni        (rst_n),
    .usb_dp_i      (dp),
    .usb_dn_i      (dn),
    .cfg_pinflip_i (flip),
    .usb_oe_i      (oe),
    .us_tick_o     (mon.us_tick),
    .line_state_o  (mon.line_state),
    .rx_j_det_o    (mon.rx_j_det),
    .rx_idle_det_o (mon.rx_idle_det),
    .se1_err_o     (mon.se1_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int k     = -1;
  int jcnt  = 0;
  int scnt  = 0;

  logic [1:0] h_pin  [NMAX];
  bit         h_oe   [NMAX];
  bit         h_flip [NMAX];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, k, got, exp);
    end
  endtask

  // Line state seen after edge j: pins sampled two edges earlier.
  function automatic int line_at(int j);
    logic [1:0] p;
    if (j < 0) return 0;
    p = (j < 2) ? 2'b00 : h_pin[j-2];
    if (h_flip[j]) p = {p[0], p[1]};
    case (p)
      2'b10:   return 1;
      2'b01:   return 2;
      2'b00:   return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int sat(int v);
    return (v > MAXR) ? MAXR : v;
  endfunction

  // Age of the current line state after edge m, zeroed by driving.
  function automatic int run_at(int m);
    if (m < 0) return 0;
    for (int j = m; j >= 0; j--) begin
      if (h_oe[j]) return sat(m - j);
      if (line_at(j) != line_at(j - 1)) return sat(m - j + 1);
      if (m - j >= MAXR) return MAXR;
    end
    return sat(m + 1);
  endfunction

  task automatic check_edge(int e);
    int lp;
    int rp;
    bit drv;
    lp  = line_at(e - 1);
    rp  = run_at(e - 1);
    drv = h_oe[e];
    check_eq("line", 32'(mon.line_state), 32'(line_at(e)));
    check_eq("j_det", 32'(mon.rx_j_det), 32'(!drv && lp == 1 && rp == BC));
    check_eq("idle", 32'(mon.rx_idle_det), 32'(!drv && lp == 1 && rp == MAXR));
    check_eq("se1", 32'(mon.se1_err), 32'(!drv && lp == 3 && rp == BC));
    check_eq("tick", 32'(mon.us_tick), 32'((e % TC) == TC - 1));
    if (mon.rx_j_det) jcnt++;
    if (mon.se1_err) scnt++;
  endtask

  task automatic edge_and_check();
    @(posedge clk);
    k++;
    #1;
    check_edge(k);
  endtask

  task automatic record();
    if (k + 1 >= NMAX) begin
      check_eq("history_overflow", 32'(k), 32'(NMAX - 2));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "history overflow");
    end
    h_pin[k+1]  = {dp, dn};
    h_oe[k+1]   = oe;
    h_flip[k+1] = flip;
  endtask

  task automatic step(logic [1:0] p, logic o);
    @(negedge clk);
    {dp, dn} = p;
    oe = o;
    record();
    edge_and_check();
  endtask

  task automatic seg(logic [1:0] p, logic o, int n);
    repeat (n) step(p, o);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    k = -1;
    record();
    edge_and_check();
  endtask

  task automatic check_all_zero(string tag);
    check_eq({tag, "_tick"}, 32'(mon.us_tick), 32'd0);
    check_eq({tag, "_line"}, 32'(mon.line_state), 32'd0);
    check_eq({tag, "_jdet"}, 32'(mon.rx_j_det), 32'd0);
    check_eq({tag, "_idle"}, 32'(mon.rx_idle_det), 32'd0);
    check_eq({tag, "_se1"}, 32'(mon.se1_err), 32'd0);
  endtask

  initial begin
    int len;
    int sel;
    logic [1:0] p;
    logic o;

    #12;
    check_all_zero("reset");
    release_reset();

    seg(2'b00, 1'b0, 150);

    seg(2'b10, 1'b0, 40);
    seg(2'b01, 1'b0, 10);

    jcnt = 0;
    seg(2'b10, 1'b0, 20);
    seg(2'b01, 1'b0, 2);
    seg(2'b10, 1'b0, 40);
    check_eq("glitch_jdet_count", 32'(jcnt), 32'd2);

    seg(2'b00, 1'b0, 6);
    flip = 1'b1;
    jcnt = 0;
    seg(2'b01, 1'b0, 40);
    check_eq("flip_jdet_count", 32'(jcnt), 32'd1);
    seg(2'b00, 1'b0, 6);
    flip = 1'b0;
    seg(2'b00, 1'b0, 4);

    jcnt = 0;
    seg(2'b10, 1'b1, 50);
    check_eq("oe_jdet_count", 32'(jcnt), 32'd0);
    seg(2'b10, 1'b0, 20);
    check_eq("oe_release_jdet", 32'(jcnt), 32'd1);

    scnt = 0;
    seg(2'b11, 1'b0, 10);
    seg(2'b10, 1'b0, 5);
    check_eq("se1_count", 32'(scnt), 32'd1);

    seg(2'b10, 1'b0, 40);
    check_eq("idle_before_rst", 32'(mon.rx_idle_det), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("hold_rst");
    release_reset();

    for (int s = 0; s < 110; s++) begin
      len = $urandom_range(1, 40);
      sel = $urandom_range(0, 99);
      if (sel < 50)      p = 2'b10;
      else if (sel < 70) p = 2'b01;
      else if (sel < 85) p = 2'b00;
      else               p = 2'b11;
      o = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 9) == 0) flip = ~flip;
      if ($urandom_range(0, 5) == 0) len = $urandom_range(1, 3);
      seg(p, o, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
